// File: rtl/x5_unit_arbiter_if.sv
// Handshake bundle between two requesters, the arbiter and the shared X->S compute unit.
// master = environment (requesters + unit model), slave = the arbiter.
interface x5_unit_arbiter_if #(
  parameter int unsigned XW = 5,
  parameter int unsigned SW = 6
);
  logic          req0_valid;
  logic [XW-1:0] req0_x;
  logic          req0_ready;
  logic          rsp0_valid;
  logic [SW-1:0] rsp0_s;
  logic          rsp0_ready;

  logic          req1_valid;
  logic [XW-1:0] req1_x;
  logic          req1_ready;
  logic          rsp1_valid;
  logic [SW-1:0] rsp1_s;
  logic          rsp1_ready;

  logic [XW-1:0] unit_x;
  logic [SW-1:0] unit_s;
  logic          busy;

  modport master (
    output req0_valid, req0_x, rsp0_ready,
    output req1_valid, req1_x, rsp1_ready,
    output unit_s,
    input  req0_ready, rsp0_valid, rsp0_s,
    input  req1_ready, rsp1_valid, rsp1_s,
    input  unit_x, busy
  );

  modport slave (
    input  req0_valid, req0_x, rsp0_ready,
    input  req1_valid, req1_x, rsp1_ready,
    input  unit_s,
    output req0_ready, rsp0_valid, rsp0_s,
    output req1_ready, rsp1_valid, rsp1_s,
    output unit_x, busy
  );
endinterface

// File: rtl/x5_unit_arbiter.sv
// Round-robin sequencer sharing one combinational X->S unit between two requesters,
// one operation in flight: accept, hold unit_x for HOLD_CYCLES, capture S, return it.
module x5_unit_arbiter #(
  parameter int unsigned XW          = 5,
  parameter int unsigned SW          = 6,
  parameter int unsigned HOLD_CYCLES = 1
) (
  input logic               clk,
  input logic               rst_n,
  x5_unit_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StDrive, StResp} state_e;

  localparam logic [3:0] HoldLast = 4'(HOLD_CYCLES - 1);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic [XW-1:0] unit_x_q, unit_x_d;
  logic          rsp0_valid_q, rsp0_valid_d;
  logic          rsp1_valid_q, rsp1_valid_d;
  logic [SW-1:0] rsp0_s_q, rsp0_s_d;
  logic [SW-1:0] rsp1_s_q, rsp1_s_d;
  logic          gnt0, gnt1;
  logic          owner_rsp_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      owner_q      <= 1'b0;
      last_q       <= 1'b1;
      unit_x_q     <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_s_q     <= '0;
      rsp1_s_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      unit_x_q     <= unit_x_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_s_q     <= rsp0_s_d;
      rsp1_s_q     <= rsp1_s_d;
    end
  end

  // On a tie the requester that did not win last time is granted.
  assign gnt0 = bus.req0_valid & (~bus.req1_valid | last_q);
  assign gnt1 = bus.req1_valid & (~bus.req0_valid | ~last_q);
  assign owner_rsp_ready = owner_q ? bus.rsp1_ready : bus.rsp0_ready;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    owner_d        = owner_q;
    last_d         = last_q;
    unit_x_d       = unit_x_q;
    rsp0_valid_d   = rsp0_valid_q;
    rsp1_valid_d   = rsp1_valid_q;
    rsp0_s_d       = rsp0_s_q;
    rsp1_s_d       = rsp1_s_q;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;

    case (state_q)
      StIdle: begin
        bus.req0_ready = gnt0;
        bus.req1_ready = gnt1;
        if (gnt0 || gnt1) begin
          unit_x_d = gnt1 ? bus.req1_x : bus.req0_x;
          owner_d  = gnt1;
          last_d   = gnt1;
          cnt_d    = '0;
          state_d  = StDrive;
        end
      end
      StDrive: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == HoldLast) begin
          if (owner_q) begin
            rsp1_s_d     = bus.unit_s;
            rsp1_valid_d = 1'b1;
          end else begin
            rsp0_s_d     = bus.unit_s;
            rsp0_valid_d = 1'b1;
          end
          state_d = StResp;
        end
      end
      StResp: begin
        if (owner_rsp_ready) begin
          rsp0_valid_d = 1'b0;
          rsp1_valid_d = 1'b0;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.unit_x     = unit_x_q;
  assign bus.rsp0_valid = rsp0_valid_q;
  assign bus.rsp1_valid = rsp1_valid_q;
  assign bus.rsp0_s     = rsp0_s_q;
  assign bus.rsp1_s     = rsp1_s_q;
  assign bus.busy       = (state_q != StIdle);

endmodule

// File: tb/tb_x5_unit_arbiter.sv
// Bench: two arbiter instances (HOLD_CYCLES 1 and 3) sharing one stimulus path selected by sel,
// checked against a transaction-level model (grant = alternate on ties, result = x + 31).
module tb_x5_unit_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       sel = 1'b0;
  logic       v0 = 1'b0, v1 = 1'b0, r0 = 1'b0, r1 = 1'b0;
  logic [4:0] x0 = '0, x1 = '0;

  int checks = 0;
  int failures = 0;
  bit lg [2];

  x5_unit_arbiter_if #(.XW(5), .SW(6)) ifa ();
  x5_unit_arbiter_if #(.XW(5), .SW(6)) ifb ();

  assign ifa.req0_valid = v0 & ~sel;
  assign ifa.req1_valid = v1 & ~sel;
  assign ifa.req0_x     = x0;
  assign ifa.req1_x     = x1;
  assign ifa.rsp0_ready = r0 & ~sel;
  assign ifa.rsp1_ready = r1 & ~sel;
  assign ifa.unit_s     = {1'b0, ifa.unit_x} + 6'd31;

  assign ifb.req0_valid = v0 & sel;
  assign ifb.req1_valid = v1 & sel;
  assign ifb.req0_x     = x0;
  assign ifb.req1_x     = x1;
  assign ifb.rsp0_ready = r0 & sel;
  assign ifb.rsp1_ready = r1 & sel;
  assign ifb.unit_s     = {1'b0, ifb.unit_x} + 6'd31;

  x5_unit_arbiter #(.XW(5), .SW(6), .HOLD_CYCLES(1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa.slave)
  );

  x5_unit_arbiter #(.XW(5), .SW(6), .HOLD_CYCLES(3)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb.slave)
  );

  logic       o_rdy0, o_rdy1, o_rv0, o_rv1, o_busy;
  logic [5:0] o_rs0, o_rs1;
  logic [4:0] o_unit_x;
  assign o_rdy0   = sel ? ifb.req0_ready : ifa.req0_ready;
  assign o_rdy1   = sel ? ifb.req1_ready : ifa.req1_ready;
  assign o_rv0    = sel ? ifb.rsp0_valid : ifa.rsp0_valid;
  assign o_rv1    = sel ? ifb.rsp1_valid : ifa.rsp1_valid;
  assign o_rs0    = sel ? ifb.rsp0_s     : ifa.rsp0_s;
  assign o_rs1    = sel ? ifb.rsp1_s     : ifa.rsp1_s;
  assign o_busy   = sel ? ifb.busy       : ifa.busy;
  assign o_unit_x = sel ? ifb.unit_x     : ifa.unit_x;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s (sel=%0d) observed=%0d expected=%0d", tag, sel, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    v0 = 1'b0; v1 = 1'b0; r0 = 1'b0; r1 = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    lg[0] = 1'b1;
    lg[1] = 1'b1;
  endtask

  task automatic check_reset_state();
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #0;
      check("rst_unit_x", o_unit_x, 0);
      check("rst_busy", o_busy, 0);
      check("rst_rsp_valid", {o_rv1, o_rv0}, 0);
      check("rst_rsp_s", {o_rs1, o_rs0}, 0);
    end
    sel = 1'b0;
  endtask

  // One full transaction on the selected instance; the loser of a tie simply withdraws.
  task automatic do_op(input logic a0, input logic a1, input logic [4:0] d0,
                       input logic [4:0] d1, input int delay);
    int         hold;
    bit         w;
    logic [4:0] xw;
    logic [5:0] exp;
    hold = sel ? 3 : 1;
    w    = (a0 && a1) ? !lg[sel] : a1;
    xw   = w ? d1 : d0;
    exp  = 6'(xw) + 6'd31;

    @(posedge clk); #1;
    v0 = a0; v1 = a1; x0 = d0; x1 = d1;
    @(negedge clk);
    check("req0_ready", o_rdy0, (w == 1'b0));
    check("req1_ready", o_rdy1, (w == 1'b1));
    check("busy_idle", o_busy, 0);
    @(posedge clk); #1;
    v0 = 1'b0; v1 = 1'b0;
    lg[sel] = w;

    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("drive_unit_x", o_unit_x, xw);
      check("drive_busy", o_busy, 1);
      check("drive_no_rsp", {o_rv1, o_rv0}, 0);
      @(posedge clk);
    end
    #1;
    if (w) v0 = 1'b1; else v1 = 1'b1;

    for (int d = 0; d <= delay; d++) begin
      @(negedge clk);
      check("rsp_valid_owner", w ? o_rv1 : o_rv0, 1);
      check("rsp_s_owner", w ? o_rs1 : o_rs0, exp);
      check("rsp_valid_other", w ? o_rv0 : o_rv1, 0);
      check("resp_no_ready", {o_rdy1, o_rdy0}, 0);
      check("resp_busy", o_busy, 1);
      check("resp_unit_x", o_unit_x, xw);
      if (d < delay) @(posedge clk);
    end
    if (w) r1 = 1'b1; else r0 = 1'b1;
    v0 = 1'b0; v1 = 1'b0;
    @(posedge clk); #1;
    r0 = 1'b0; r1 = 1'b0;
    @(negedge clk);
    check("rsp_done", {o_rv1, o_rv0}, 0);
    check("busy_done", o_busy, 0);
    check("unit_x_kept", o_unit_x, xw);
  endtask

  initial begin
    lg[0] = 1'b1;
    lg[1] = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_reset_state();

    // Single requesters on the HOLD=1 instance.
    sel = 1'b0;
    do_op(1'b1, 1'b0, 5'd5, 5'd0, 0);
    do_op(1'b0, 1'b1, 5'd0, 5'd31, 0);

    // Alternation after reset: 0,1,0,1.
    do_reset();
    do_op(1'b1, 1'b1, 5'd10, 5'd16, 0);
    do_op(1'b1, 1'b1, 5'd10, 5'd16, 0);
    do_op(1'b1, 1'b1, 5'd10, 5'd16, 0);
    do_op(1'b1, 1'b1, 5'd10, 5'd16, 0);

    // Response back-pressure with the other requester waiting.
    do_op(1'b1, 1'b0, 5'd23, 5'd0, 4);

    // Response ready while no response pending does nothing.
    @(posedge clk); #1 r0 = 1'b1; r1 = 1'b1;
    @(negedge clk);
    check("idle_rdy_rsp", {o_rv1, o_rv0}, 0);
    check("idle_rdy_busy", o_busy, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("idle_rdy_rsp2", {o_rv1, o_rv0}, 0);
    r0 = 1'b0; r1 = 1'b1; r1 = 1'b0;

    // Longer hold on the HOLD=3 instance.
    sel = 1'b1;
    do_op(1'b1, 1'b0, 5'd9, 5'd0, 0);
    do_op(1'b1, 1'b1, 5'd1, 5'd2, 1);

    // Reset during DRIVE aborts the operation.
    sel = 1'b0;
    @(posedge clk); #1 v0 = 1'b1; x0 = 5'd18;
    @(posedge clk); #1 v0 = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    lg[0] = 1'b1;
    lg[1] = 1'b1;
    check_reset_state();
    repeat (3) begin
      @(negedge clk);
      check("abort_no_rsp", {o_rv1, o_rv0}, 0);
    end
    do_op(1'b1, 1'b0, 5'd18, 5'd0, 0);

    // Randomized traffic on both instances.
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int i = 0; i < 16; i++) begin
        logic       a0, a1;
        logic [4:0] d0, d1;
        a0 = 1'($urandom_range(0, 1));
        a1 = a0 ? 1'($urandom_range(0, 1)) : 1'b1;
        d0 = 5'($urandom);
        d1 = 5'($urandom);
        do_op(a0, a1, d0, d1, int'($urandom_range(0, 3)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
